// File: rtl/random_pkg.sv
// Shared constants and types for the game random-number source.
// Default LFSR geometry, reset seed and the draw-operation encoding.
package random_pkg;

   localparam int RAND_WIDTH = 16;

   localparam logic [RAND_WIDTH-1:0] RAND_TAPS = 16'hB400;
   localparam logic [RAND_WIDTH-1:0] RAND_SEED = 16'hACE1;

   typedef logic [RAND_WIDTH-1:0] rand_t;

   // What the state register does on the coming edge, highest priority first.
   typedef enum logic [1:0] {
      OP_IDLE  = 2'd0,
      OP_RESET = 2'd1,
      OP_SEED  = 2'd2,
      OP_DRAW  = 2'd3
   } rand_op_e;

endpackage

// File: rtl/random_gen_lfsr_step.sv
// One Galois LFSR step: shift right, fold TAPS in when the
// bit shifted out was a one. Purely combinational.
module lfsr_step
   import random_pkg::*;
#(
   parameter int                   WIDTH = RAND_WIDTH,
   parameter logic [WIDTH-1:0]     TAPS  = RAND_TAPS
) (
   input  logic [WIDTH-1:0] i_state,
   output logic [WIDTH-1:0] o_next_state
);

   logic [WIDTH-1:0] w_shift;
   logic             w_lsb;

   assign w_lsb   = i_state[0];
   assign w_shift = i_state >> 1;

   // Toggle the tap positions only when a one falls off the bottom.
   always_comb begin
      o_next_state = w_shift;
      if (w_lsb) begin
         o_next_state = w_shift ^ TAPS;
      end
   end

endmodule

// File: rtl/random_gen.sv
// Request-driven LFSR draw unit: returns offset + (new_state & mask)
// one cycle after each request, with reseed and zero-seed protection.
module random_gen
   import random_pkg::*;
#(
   parameter int               WIDTH = RAND_WIDTH,
   parameter logic [WIDTH-1:0] TAPS  = RAND_TAPS,
   parameter logic [WIDTH-1:0] SEED  = RAND_SEED
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req,
   input  logic [WIDTH-1:0] mask,
   input  logic [WIDTH-1:0] offset,
   input  logic             seed_load,
   input  logic [WIDTH-1:0] seed_in,
   output logic             ack,
   output logic [WIDTH-1:0] rdata,
   output logic [WIDTH-1:0] state
);

   logic [WIDTH-1:0] r_state;
   logic             r_ack;
   logic [WIDTH-1:0] r_rdata;

   logic [WIDTH-1:0] w_next;
   logic [WIDTH-1:0] w_masked;
   logic [WIDTH-1:0] w_sum;
   logic [WIDTH-1:0] w_seed_sel;
   rand_op_e         w_op;

   lfsr_step #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS)
   ) u_step (
      .i_state      (r_state),
      .o_next_state (w_next)
   );

   // The draw result is built from the state the draw moves to;
   // the sum wraps naturally at WIDTH bits.
   assign w_masked = w_next & mask;
   assign w_sum    = offset + w_masked;

   // A zero seed would lock the LFSR at zero forever, so it is
   // replaced by the reset seed.
   assign w_seed_sel = (seed_in == '0) ? SEED : seed_in;

   // Fixed priority: reset, then reseed, then draw.
   always_comb begin
      w_op = OP_IDLE;
      if (rst) begin
         w_op = OP_RESET;
      end else if (seed_load) begin
         w_op = OP_SEED;
      end else if (req) begin
         w_op = OP_DRAW;
      end
   end

   // State, acknowledge pulse and held result update together.
   always_ff @(posedge clk) begin
      unique case (w_op)
         OP_RESET: begin
            r_state <= SEED;
            r_ack   <= 1'b0;
            r_rdata <= '0;
         end
         OP_SEED: begin
            r_state <= w_seed_sel;
            r_ack   <= 1'b0;
         end
         OP_DRAW: begin
            r_state <= w_next;
            r_ack   <= 1'b1;
            r_rdata <= w_sum;
         end
         default: begin
            r_ack   <= 1'b0;
         end
      endcase
   end

   assign ack   = r_ack;
   assign rdata = r_rdata;
   assign state = r_state;

   // The all-zero state must be unreachable once out of reset.
   a_state_nonzero : assert property (
      @(posedge clk) disable iff (rst)
      state != '0
   );

   // An acknowledge only ever follows a plain draw request.
   a_ack_source : assert property (
      @(posedge clk) disable iff (rst)
      ack |-> $past(req && !seed_load && !rst)
   );

endmodule

// File: tb/tb_random_gen.sv
// Self-checking bench for random_gen: per-cycle model compare,
// directed literal expectations and a full-period walk.
`timescale 1ns/1ps
module tb_random_gen;

   localparam logic [15:0] TAPS = 16'hB400;
   localparam logic [15:0] SEED = 16'hACE1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0;
   logic [15:0] mask = '0;
   logic [15:0] offset = '0;
   logic        seed_load = 1'b0;
   logic [15:0] seed_in = '0;
   logic        ack;
   logic [15:0] rdata;
   logic [15:0] state;

   random_gen dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .mask      (mask),
      .offset    (offset),
      .seed_load (seed_load),
      .seed_in   (seed_in),
      .ack       (ack),
      .rdata     (rdata),
      .state     (state)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Behavioural model
   logic        mv = 1'b0;
   logic        m_ack;
   logic [15:0] m_rdata;
   logic [15:0] m_state;

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      int unsigned v;
      int unsigned n;
      v = s;
      n = v / 2;
      if (v % 2 == 1) n = n ^ TAPS;
      return n[15:0];
   endfunction

   always @(posedge clk) begin
      int unsigned sum;
      logic [15:0] ns;
      if (rst) begin
         mv      <= 1'b1;
         m_state <= SEED;
         m_ack   <= 1'b0;
         m_rdata <= 16'h0000;
      end else if (seed_load) begin
         m_state <= (seed_in == 16'h0000) ? SEED : seed_in;
         m_ack   <= 1'b0;
      end else if (req) begin
         ns  = lfsr_next(m_state);
         sum = (int'(offset) + int'(ns & mask)) % 65536;
         m_state <= ns;
         m_ack   <= 1'b1;
         m_rdata <= sum[15:0];
      end else begin
         m_ack   <= 1'b0;
      end
   end

   // Literal expectations for the edge that follows their setting
   logic        lit_en = 1'b0;
   logic        lit_ack;
   logic [15:0] lit_rdata;
   logic [15:0] lit_state;
   string       lit_name = "";

   // Full-period walk bookkeeping
   logic        per_on = 1'b0;
   int          per_idx = 0;
   bit          seen [65536];

   task automatic cmp(input string nm, input logic [15:0] a,
                      input logic [15:0] e);
      n_cmp++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
      end
   endtask

   always @(negedge clk) begin
      if (mv) begin
         cmp("model_ack", {15'd0, ack}, {15'd0, m_ack});
         cmp("model_rdata", rdata, m_rdata);
         cmp("model_state", state, m_state);
         if (lit_en) begin
            cmp({lit_name, "_ack"}, {15'd0, ack}, {15'd0, lit_ack});
            cmp({lit_name, "_rdata"}, rdata, lit_rdata);
            cmp({lit_name, "_state"}, state, lit_state);
         end
         if (per_on && ack === 1'b1) begin
            cmp("period_nonzero", {15'd0, state == 16'h0}, 16'h0);
            if (per_idx == 65534) begin
               cmp("period_return", state, SEED);
            end else begin
               cmp("period_early_seed", {15'd0, state == SEED}, 16'h0);
               cmp("period_repeat", {15'd0, seen[state]}, 16'h0);
            end
            seen[state] = 1'b1;
            per_idx++;
         end
      end
   end

   task automatic cyc(input logic r, input logic sl, input logic [15:0] si,
                      input logic q, input logic [15:0] m,
                      input logic [15:0] o, input logic le,
                      input logic ea, input logic [15:0] er,
                      input logic [15:0] es, input string nm);
      @(negedge clk);
      #1;
      rst       = r;
      seed_load = sl;
      seed_in   = si;
      req       = q;
      mask      = m;
      offset    = o;
      lit_en    = le;
      lit_ack   = ea;
      lit_rdata = er;
      lit_state = es;
      lit_name  = nm;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      cyc(1, 0, 0, 0, 0, 0, 1, 0, 16'h0000, 16'hACE1, "reset");
      cyc(1, 0, 0, 0, 0, 0, 1, 0, 16'h0000, 16'hACE1, "reset2");
      cyc(0, 0, 0, 1, 16'hFFFF, 0, 1, 1, 16'hE270, 16'hE270, "draw1");
      cyc(0, 0, 0, 1, 16'hFFFF, 0, 1, 1, 16'h7138, 16'h7138, "draw2");
      cyc(0, 0, 0, 1, 16'hFFFF, 0, 1, 1, 16'h389C, 16'h389C, "draw3");
      cyc(0, 0, 0, 1, 16'hFFFF, 0, 1, 1, 16'h1C4E, 16'h1C4E, "draw4");
      cyc(0, 0, 0, 0, 16'hFFFF, 0, 1, 0, 16'h1C4E, 16'h1C4E, "idle_hold");
      cyc(1, 0, 0, 0, 0, 0, 1, 0, 16'h0000, 16'hACE1, "reset3");
      cyc(0, 0, 0, 1, 16'h0007, 16'h0013, 1, 1, 16'h0013, 16'hE270, "mask7_a");
      cyc(0, 0, 0, 1, 16'h0007, 16'h0013, 1, 1, 16'h0013, 16'h7138, "mask7_b");
      cyc(1, 0, 0, 0, 0, 0, 1, 0, 16'h0000, 16'hACE1, "reset4");
      cyc(0, 0, 0, 1, 16'hFFFF, 16'h2000, 1, 1, 16'h0270, 16'hE270, "wrap");
      cyc(0, 1, 16'h0000, 0, 0, 0, 1, 0, 16'h0270, 16'hACE1, "seed_zero");
      cyc(0, 1, 16'h0001, 1, 16'hFFFF, 0, 1, 0, 16'h0270, 16'h0001, "seed_req");
      cyc(0, 0, 0, 1, 16'hFFFF, 0, 1, 1, 16'hB400, 16'hB400, "after_seed");
      cyc(0, 0, 0, 1, 16'hFFFF, 0, 1, 1, 16'h5A00, 16'h5A00, "after_seed2");
      cyc(1, 0, 0, 1, 16'hFFFF, 0, 1, 0, 16'h0000, 16'hACE1, "rst_req");
      cyc(0, 0, 0, 0, 0, 0, 1, 0, 16'h0000, 16'hACE1, "post_rst");
      cyc(0, 1, 16'h1234, 0, 0, 0, 1, 0, 16'h0000, 16'h1234, "seed_plain");
      cyc(0, 0, 0, 1, 16'h00F0, 16'h0001, 1, 1, 16'h0011, 16'h091A, "draw_seeded");
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "");
      per_on = 1'b1;
      for (int i = 0; i < 65535; i++) begin
         cyc(0, 0, 0, 1, 16'hFFFF, 0, 0, 0, 0, 0, "");
      end
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "");
      per_on = 1'b0;
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "");
      n_cmp++;
      if (per_idx != 65535) begin
         n_bad++;
         $display("FAIL period_count: got %0d expected 65535", per_idx);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
